// File: rtl/csr_file.sv
// Machine-mode CSR register file: decoded read mux, masked writes, 64-bit cycle/instret
// counters, and trap/MRET handling with a one-cycle redirect pulse to the front end.
module csr_file #(
   parameter int          CSR_ADDR_WIDTH = 20,
   parameter logic [31:0] MTVEC_RESET    = 32'h0000_0000,
   parameter int          RETIRE_W       = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      csr_valid,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
   output logic [31:0]               csr_data,
   input  logic                      csr_wr_en,
   input  logic [31:0]               csr_wr_data,
   output logic                      csr_illegal,
   input  logic [RETIRE_W-1:0]       retire_cnt,
   input  logic                      trap_valid,
   input  logic [31:0]               trap_pc,
   input  logic [4:0]                trap_cause,
   input  logic                      mret_valid,
   output logic                      csr_branch,
   output logic [31:0]               csr_branch_pc
);

   // state    | meaning
   // IDLE     | accepting traps, MRETs and CSR writes
   // REDIRECT | csr_branch asserted for one cycle; events and writes ignored
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_REDIRECT = 1'b1;

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_CYCLE     = 12'hC00;
   localparam logic [11:0] A_INSTRET   = 12'hC02;
   localparam logic [11:0] A_CYCLEH    = 12'hC80;
   localparam logic [11:0] A_INSTRETH  = 12'hC82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   logic [0:0]  state;
   logic        mie;
   logic        mpie;
   logic [29:0] mtvec;
   logic [29:0] mepc;
   logic [31:0] mscratch;
   logic [31:0] mcause;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [31:0] branch_pc;

   logic [11:0] addr;
   logic        mapped;
   logic        idle;
   logic        take_trap;
   logic        take_mret;
   logic        wr_ok;
   logic [63:0] retire_ext;
   logic        unused_addr;

   assign addr        = csr_address[11:0];
   assign unused_addr = ^csr_address[CSR_ADDR_WIDTH-1:12];
   assign retire_ext  = {{(64-RETIRE_W){1'b0}}, retire_cnt};

   always_comb begin
      mapped   = 1'b1;
      csr_data = 32'h0;
      case (addr)
         A_MSTATUS:              csr_data = {24'h0, mpie, 3'b000, mie, 3'b000};
         A_MTVEC:                csr_data = {mtvec, 2'b00};
         A_MSCRATCH:             csr_data = mscratch;
         A_MEPC:                 csr_data = {mepc, 2'b00};
         A_MCAUSE:               csr_data = mcause;
         A_MCYCLE,   A_CYCLE:    csr_data = mcycle[31:0];
         A_MCYCLEH,  A_CYCLEH:   csr_data = mcycle[63:32];
         A_MINSTRET, A_INSTRET:  csr_data = minstret[31:0];
         A_MINSTRETH,A_INSTRETH: csr_data = minstret[63:32];
         A_MHARTID:              csr_data = 32'h0;
         default:                mapped   = 1'b0;
      endcase
   end

   assign csr_illegal = csr_valid & (~mapped | (csr_wr_en & (addr[11:10] == 2'b11)));

   // Trap beats MRET beats a CSR write; nothing is accepted while the redirect is out.
   assign idle      = (state == ST_IDLE);
   assign take_trap = idle & trap_valid;
   assign take_mret = idle & mret_valid & ~trap_valid;
   assign wr_ok     = idle & ~trap_valid & ~mret_valid & csr_valid & csr_wr_en & ~csr_illegal;

   assign csr_branch    = (state == ST_REDIRECT);
   assign csr_branch_pc = branch_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mie       <= 1'b0;
         mpie      <= 1'b0;
         mtvec     <= MTVEC_RESET[31:2];
         mepc      <= 30'h0;
         mscratch  <= 32'h0;
         mcause    <= 32'h0;
         mcycle    <= 64'h0;
         minstret  <= 64'h0;
         branch_pc <= 32'h0;
      end else begin
         // A counter half write suppresses that counter's increment for the cycle.
         if (wr_ok && addr == A_MCYCLE)        mcycle[31:0]  <= csr_wr_data;
         else if (wr_ok && addr == A_MCYCLEH)  mcycle[63:32] <= csr_wr_data;
         else                                  mcycle        <= mcycle + 64'd1;

         if (wr_ok && addr == A_MINSTRET)       minstret[31:0]  <= csr_wr_data;
         else if (wr_ok && addr == A_MINSTRETH) minstret[63:32] <= csr_wr_data;
         else                                   minstret        <= minstret + retire_ext;

         if (take_trap) begin
            state     <= ST_REDIRECT;
            mepc      <= trap_pc[31:2];
            mcause    <= {27'h0, trap_cause};
            mpie      <= mie;
            mie       <= 1'b0;
            branch_pc <= {mtvec, 2'b00};
         end else if (take_mret) begin
            state     <= ST_REDIRECT;
            mie       <= mpie;
            mpie      <= 1'b1;
            branch_pc <= {mepc, 2'b00};
         end else begin
            state <= ST_IDLE;
            if (wr_ok) begin
               case (addr)
                  A_MSTATUS: begin
                     mie  <= csr_wr_data[3];
                     mpie <= csr_wr_data[7];
                  end
                  A_MTVEC:    mtvec    <= csr_wr_data[31:2];
                  A_MSCRATCH: mscratch <= csr_wr_data;
                  A_MEPC:     mepc     <= csr_wr_data[31:2];
                  A_MCAUSE:   mcause   <= csr_wr_data;
                  default:    ;
               endcase
            end
         end
      end
   end

endmodule
